// File: rtl/freq_counter_pkg.sv
// Shared types and default constants for the frequency counter control path.
// Contents: FSM state encoding (also exported on dbg_state) and default
// parameter values for the measurement sequencer and its gate window timer.
package freq_counter_pkg;

   localparam int unsigned STATE_W            = 2;
   localparam int unsigned DEF_PERIOD_W       = 8;
   localparam int unsigned DEF_PRESCALE       = 1000;
   localparam int unsigned DEF_DEFAULT_PERIOD = 10;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_COUNT = 2'd2,
      ST_LATCH = 2'd3
   } state_e;

endpackage

// File: rtl/gate_window_timer.sv
// Gate window timer: times a window of period*PRESCALE clk cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse; loads the counters with period (the window begins the next cycle)
//   period     : window length in units of PRESCALE cycles (nonzero)
//   done       : combinational pulse during the last cycle of the window
module gate_window_timer
   import freq_counter_pkg::*;
#(
   parameter int unsigned PERIOD_W = DEF_PERIOD_W,
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [PERIOD_W-1:0] period,
   output logic                done
);

   localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]    r_pre;
   logic [PERIOD_W-1:0] r_per;
   logic                r_active;

   // Last cycle: final period unit and final prescale tick.
   assign done = r_active && (r_per == PERIOD_W'(1)) && (r_pre == PRE_LAST);

   // Prescale counter rolls 0..PRESCALE-1, period counter counts down to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre    <= '0;
         r_per    <= '0;
         r_active <= 1'b0;
      end else if (start) begin
         r_pre    <= '0;
         r_per    <= period;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (done) begin
            r_active <= 1'b0;
         end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_per <= r_per - PERIOD_W'(1);
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/freq_measure_sequencer.sv
// Measurement sequencer for the frequency counter: clear edge counter, count
// for period_q*PRESCALE cycles, then strobe the result into the display.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : run measurements while high
//   single_shot    : 1 = one window per enable rising edge, 0 = continuous
//   load_period    : capture period_in (ignored when period_in is zero)
//   period_in      : new gate period in PRESCALE units
//   cnt_overflow   : sticky overflow from the edge counter
//   cnt_clear      : clear edge counter (1 cycle)
//   cnt_en         : edge counter enable during the gate window
//   result_valid   : 1-cycle strobe to latch the count
//   result_ovf     : overflow flag qualified by result_valid
//   period_q       : active gate period
//   busy, dbg_state: activity flag and encoded FSM state
module freq_measure_sequencer
   import freq_counter_pkg::*;
#(
   parameter int unsigned PERIOD_W       = DEF_PERIOD_W,
   parameter int unsigned PRESCALE       = DEF_PRESCALE,
   parameter int unsigned DEFAULT_PERIOD = DEF_DEFAULT_PERIOD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                single_shot,
   input  logic                load_period,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                cnt_overflow,
   output logic                cnt_clear,
   output logic                cnt_en,
   output logic                result_valid,
   output logic                result_ovf,
   output logic [PERIOD_W-1:0] period_q,
   output logic                busy,
   output logic [STATE_W-1:0]  dbg_state
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_armed;
   logic                r_pend;
   logic [PERIOD_W-1:0] r_pend_val;
   logic                w_load_ok;
   logic                w_done;

   assign w_load_ok = load_period && (period_in != '0);

   gate_window_timer #(
      .PERIOD_W (PERIOD_W),
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (r_state == ST_CLEAR),
      .period (period_q),
      .done   (w_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; dropping enable aborts a window in progress.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (enable && r_armed) w_state_nxt = ST_CLEAR;
         ST_CLEAR: w_state_nxt = enable ? ST_COUNT : ST_IDLE;
         ST_COUNT: begin
            if (!enable)    w_state_nxt = ST_IDLE;
            else if (w_done) w_state_nxt = ST_LATCH;
         end
         ST_LATCH: w_state_nxt = (enable && !single_shot) ? ST_CLEAR : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Moore outputs registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_clear    <= 1'b0;
         cnt_en       <= 1'b0;
         result_valid <= 1'b0;
         result_ovf   <= 1'b0;
         busy         <= 1'b0;
         dbg_state    <= STATE_W'(ST_IDLE);
      end else begin
         cnt_clear    <= (w_state_nxt == ST_CLEAR);
         cnt_en       <= (w_state_nxt == ST_COUNT);
         result_valid <= (w_state_nxt == ST_LATCH);
         result_ovf   <= (w_state_nxt == ST_LATCH) && cnt_overflow;
         busy         <= (w_state_nxt != ST_IDLE);
         dbg_state    <= STATE_W'(w_state_nxt);
      end
   end

   // Period register, deferred reload and single-shot re-arm.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_q   <= PERIOD_W'(DEFAULT_PERIOD);
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         r_armed    <= 1'b1;
      end else begin
         if (!enable)
            r_armed <= 1'b1;
         else if ((r_state == ST_LATCH) && single_shot)
            r_armed <= 1'b0;

         case (r_state)
            ST_IDLE: if (w_load_ok) period_q <= period_in;
            ST_CLEAR, ST_COUNT: begin
               if (w_load_ok) begin
                  r_pend_val <= period_in;
                  r_pend     <= 1'b1;
               end
            end
            ST_LATCH: begin
               // A direct load in this cycle wins over the deferred value.
               if (w_load_ok)   period_q <= period_in;
               else if (r_pend) period_q <= r_pend_val;
               r_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_measure_sequencer.sv
// Directed bench for freq_measure_sequencer with PRESCALE=4, PERIOD_W=8.
module tb_freq_measure_sequencer;

   localparam int unsigned PW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          single_shot;
   logic          load_period;
   logic [PW-1:0] period_in;
   logic          cnt_overflow;
   logic          cnt_clear;
   logic          cnt_en;
   logic          result_valid;
   logic          result_ovf;
   logic [PW-1:0] period_q;
   logic          busy;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   int t_clr, n_clr, n_en, t_rv, t_idle;
   logic ovf;

   freq_measure_sequencer #(
      .PERIOD_W       (PW),
      .PRESCALE       (4),
      .DEFAULT_PERIOD (10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .single_shot  (single_shot),
      .load_period  (load_period),
      .period_in    (period_in),
      .cnt_overflow (cnt_overflow),
      .cnt_clear    (cnt_clear),
      .cnt_en       (cnt_en),
      .result_valid (result_valid),
      .result_ovf   (result_ovf),
      .period_q     (period_q),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Steps up to limit cycles; cycle c=1 is the cycle after the first edge.
   // Optionally pulses load_period before step load_at and drops enable before step drop_at.
   task automatic measure(input int limit, input int load_at, input logic [PW-1:0] load_val,
                          input int drop_at,
                          output int o_clr, output int o_nclr, output int o_nen,
                          output int o_rv, output logic o_ovf, output int o_idle);
      o_clr = -1; o_nclr = 0; o_nen = 0; o_rv = -1; o_ovf = 1'b0; o_idle = -1;
      for (int c = 1; c <= limit; c++) begin
         load_period = (c == load_at);
         if (c == load_at) period_in = load_val;
         if (c == drop_at) enable = 1'b0;
         step();
         if (cnt_clear) begin
            o_nclr++;
            if (o_clr < 0) o_clr = c;
         end
         if (o_clr >= 0 && cnt_en) o_nen++;
         if (o_clr >= 0 && o_idle < 0 && dbg_state == 2'd0) o_idle = c;
         if (result_valid) begin
            o_rv  = c;
            o_ovf = result_ovf;
            break;
         end
      end
      load_period = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; single_shot = 1'b0; load_period = 1'b0;
      period_in = '0; cnt_overflow = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_clear", 32'(cnt_clear), 0);
      chk("rst_en", 32'(cnt_en), 0);
      chk("rst_rv", 32'(result_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dbg", 32'(dbg_state), 0);
      chk("rst_period", 32'(period_q), 10);

      // Reset in the middle of a window.
      enable = 1'b1;
      step();
      chk("t1_clear", 32'(cnt_clear), 1);
      chk("t1_dbg_clear", 32'(dbg_state), 1);
      step();
      chk("t1_en", 32'(cnt_en), 1);
      chk("t1_dbg_count", 32'(dbg_state), 2);
      step(); step(); step();
      reset = 1'b1; enable = 1'b0;
      step();
      reset = 1'b0;
      chk("t1_rst_en", 32'(cnt_en), 0);
      chk("t1_rst_clear", 32'(cnt_clear), 0);
      chk("t1_rst_busy", 32'(busy), 0);
      chk("t1_rst_dbg", 32'(dbg_state), 0);
      chk("t1_rst_period", 32'(period_q), 10);
      measure(60, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t1_no_rv", 32'(t_rv), 32'(-1));

      // Period 3, continuous.
      load_period = 1'b1; period_in = 8'd3;
      step();
      load_period = 1'b0;
      chk("t2_period", 32'(period_q), 3);
      enable = 1'b1;
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t2_tclr", 32'(t_clr), 1);
      chk("t2_nclr", 32'(n_clr), 1);
      chk("t2_nen", 32'(n_en), 12);
      chk("t2_trv", 32'(t_rv), 14);
      chk("t2_ovf", 32'(ovf), 0);

      // Back-to-back window with a load of 5 during COUNT.
      measure(100, 5, 8'd5, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t3_tclr", 32'(t_clr), 1);
      chk("t3_nen", 32'(n_en), 12);
      chk("t3_trv", 32'(t_rv), 14);
      chk("t3_period_latch", 32'(period_q), 3);
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t3_tclr2", 32'(t_clr), 1);
      chk("t3_period_new", 32'(period_q), 5);
      chk("t3_nen2", 32'(n_en), 20);
      chk("t3_trv2", 32'(t_rv), 22);

      // Abort on the 6th cnt_en cycle.
      measure(60, 0, '0, 8, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t4_tclr", 32'(t_clr), 1);
      chk("t4_nen", 32'(n_en), 6);
      chk("t4_tidle", 32'(t_idle), 8);
      chk("t4_no_rv", 32'(t_rv), 32'(-1));
      chk("t4_busy", 32'(busy), 0);

      // Single-shot: one window per enable rising edge.
      single_shot = 1'b1; enable = 1'b1;
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t5_nen", 32'(n_en), 20);
      chk("t5_trv", 32'(t_rv), 22);
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t5_hold_nclr", 32'(n_clr), 0);
      chk("t5_hold_no_rv", 32'(t_rv), 32'(-1));
      enable = 1'b0;
      step();
      enable = 1'b1;
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t5_rearm_trv", 32'(t_rv), 22);
      measure(40, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t5_rearm_once", 32'(t_rv), 32'(-1));

      // Overflow flag and zero-period load.
      enable = 1'b0;
      step();
      cnt_overflow = 1'b1; enable = 1'b1;
      measure(100, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t6_trv", 32'(t_rv), 22);
      chk("t6_ovf", 32'(ovf), 1);
      enable = 1'b0; cnt_overflow = 1'b0;
      step();
      load_period = 1'b1; period_in = 8'd0;
      step();
      load_period = 1'b0;
      chk("t6_zero_load", 32'(period_q), 5);

      // Minimum period: window of exactly PRESCALE cycles, continuous.
      load_period = 1'b1; period_in = 8'd1;
      step();
      load_period = 1'b0;
      chk("t7_period", 32'(period_q), 1);
      single_shot = 1'b0; enable = 1'b1;
      measure(50, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t7_nen", 32'(n_en), 4);
      chk("t7_trv", 32'(t_rv), 6);
      measure(50, 0, '0, 0, t_clr, n_clr, n_en, t_rv, ovf, t_idle);
      chk("t7_tclr2", 32'(t_clr), 1);
      chk("t7_trv2", 32'(t_rv), 6);
      enable = 1'b0;
      step(); step();
      chk("t7_idle", 32'(dbg_state), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
